// File: rtl/gray_counter_n_if.sv
// Control and status bundle for gray_counter_n.
// The master side (a sequencer or the bench) drives the controls; the counter is the slave.
interface gray_counter_n_if #(
    parameter int unsigned WIDTH = 3
) ();

    // Controls
    logic             en;
    logic             dir;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic             clr;

    // Status
    logic [WIDTH-1:0] count_gray;
    logic [WIDTH-1:0] count_bin;
    logic             overflow;
    logic             underflow;
    logic             term;

    modport master (
        output en,
        output dir,
        output load,
        output load_value,
        output clr,
        input  count_gray,
        input  count_bin,
        input  overflow,
        input  underflow,
        input  term
    );

    modport slave (
        input  en,
        input  dir,
        input  load,
        input  load_value,
        input  clr,
        output count_gray,
        output count_bin,
        output overflow,
        output underflow,
        output term
    );

endinterface

// File: rtl/gray_counter_n.sv
// Parametrised up/down Gray-code counter with binary load, wrap or saturate at the
// end of range, sticky overflow/underflow flags and a binary shadow output.
// The Gray register is loaded from the next binary value, so Gray and binary
// outputs always change on the same edge and never disagree.
module gray_counter_n #(
    parameter int unsigned WIDTH    = 3,
    parameter bit          SATURATE = 1'b0
) (
    input logic              clk,
    input logic              rst_n,
    gray_counter_n_if.slave  bus
);

    localparam logic [WIDTH-1:0] MaxVal  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZeroVal = {WIDTH{1'b0}};

    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] g_q, g_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    logic at_max;
    logic at_zero;

    assign at_max  = (b_q == MaxVal);
    assign at_zero = (b_q == ZeroVal);

    // Next-state: load beats counting; clear is applied first so a flag set wins.
    always_comb begin
        b_d   = b_q;
        ovf_d = ovf_q;
        udf_d = udf_q;

        if (bus.clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end

        if (bus.load) begin
            b_d = bus.load_value;
        end else if (bus.en) begin
            if (bus.dir) begin
                if (at_max) begin
                    ovf_d = 1'b1;
                    b_d   = SATURATE ? MaxVal : ZeroVal;
                end else begin
                    b_d = b_q + 1'b1;
                end
            end else begin
                if (at_zero) begin
                    udf_d = 1'b1;
                    b_d   = SATURATE ? ZeroVal : MaxVal;
                end else begin
                    b_d = b_q - 1'b1;
                end
            end
        end

        g_d = b_d ^ (b_d >> 1);
    end

    // Count, Gray copy and flag registers; asynchronous clear to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q   <= ZeroVal;
            g_q   <= ZeroVal;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            b_q   <= b_d;
            g_q   <= g_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    // Outputs; term follows dir within the cycle.
    always_comb begin
        bus.count_bin  = b_q;
        bus.count_gray = g_q;
        bus.overflow   = ovf_q;
        bus.underflow  = udf_q;
        bus.term       = bus.dir ? at_max : at_zero;
    end

    // The registered Gray copy must always encode the binary count.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (g_q == (b_q ^ (b_q >> 1)))
                else $error("gray/binary disagree: g=%h b=%h", g_q, b_q);
        end
    end

endmodule

// File: tb/tb_gray_counter_n.sv
// Scoreboard bench for gray_counter_n (WIDTH=3) in wrap and saturate modes.
module tb_gray_counter_n;

    typedef struct {
        string      name;
        logic [8:0] val;  // {gray, bin, ovf, udf, term}
    } sb_item_t;

    logic     clk;
    logic     rst_n;
    sb_item_t sb[$];
    int       checks;
    int       errors;

    gray_counter_n_if #(.WIDTH(3)) if_w ();
    gray_counter_n_if #(.WIDTH(3)) if_s ();

    gray_counter_n #(.WIDTH(3), .SATURATE(1'b0)) dut_w (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_w)
    );

    gray_counter_n #(.WIDTH(3), .SATURATE(1'b1)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] exp_of(input logic [2:0] b, input logic ovf,
                                          input logic udf, input logic term);
        logic [2:0] g;
        g = b ^ (b >> 1);
        return {g, b, ovf, udf, term};
    endfunction

    function automatic logic [8:0] obs_w();
        return {if_w.count_gray, if_w.count_bin, if_w.overflow, if_w.underflow, if_w.term};
    endfunction

    function automatic logic [8:0] obs_s();
        return {if_s.count_gray, if_s.count_bin, if_s.overflow, if_s.underflow, if_s.term};
    endfunction

    task automatic push(input string name, input logic [8:0] val);
        sb_item_t it;
        it.name = name;
        it.val  = val;
        sb.push_back(it);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_w.en = 1'b0; if_w.dir = 1'b1; if_w.load = 1'b0; if_w.load_value = 3'd0; if_w.clr = 1'b0;
        if_s.en = 1'b0; if_s.dir = 1'b1; if_s.load = 1'b0; if_s.load_value = 3'd0; if_s.clr = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        sb_item_t it;
        idle_inputs();
        rst_n = 1'b0;
        #2;
        push("reset_w_up", exp_of(3'd0, 1'b0, 1'b0, 1'b0));
        push("reset_s_up", exp_of(3'd0, 1'b0, 1'b0, 1'b0));
        it = sb.pop_front(); checks++;
        if (obs_w() !== it.val) begin
            errors++; $display("FAIL %s got=%h exp=%h", it.name, obs_w(), it.val);
        end
        it = sb.pop_front(); checks++;
        if (obs_s() !== it.val) begin
            errors++; $display("FAIL %s got=%h exp=%h", it.name, obs_s(), it.val);
        end
        if_w.dir = 1'b0;
        #1;
        push("reset_w_down_term", exp_of(3'd0, 1'b0, 1'b0, 1'b1));
        it = sb.pop_front(); checks++;
        if (obs_w() !== it.val) begin
            errors++; $display("FAIL %s got=%h exp=%h", it.name, obs_w(), it.val);
        end
        if_w.dir = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Eight up steps from zero: full Gray cycle, wrap sets overflow.
    task automatic test_up_wrap();
        sb_item_t it;
        if_w.dir = 1'b1;
        if_w.en  = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            logic [2:0] b;
            b = 3'(k % 8);
            push($sformatf("up_wrap_%0d", k), exp_of(b, k >= 8, 1'b0, b == 3'd7));
            tick();
            it = sb.pop_front(); checks++;
            if (obs_w() !== it.val) begin
                errors++; $display("FAIL %s got=%h exp=%h", it.name, obs_w(), it.val);
            end
        end
    endtask

    // Continue to 011 (flag stays set), hold with en=0, then async reset mid-cycle.
    task automatic test_hold_async_reset();
        sb_item_t it;
        for (int k = 1; k <= 4; k++) begin
            if_w.en = (k <= 2);
            push($sformatf("hold_%0d", k), exp_of((k <= 2) ? 3'(k) : 3'd2, 1'b1, 1'b0, 1'b0));
            tick();
            it = sb.pop_front(); checks++;
            if (obs_w() !== it.val) begin
                errors++; $display("FAIL %s got=%h exp=%h", it.name, obs_w(), it.val);
            end
        end
        #3;
        rst_n = 1'b0;
        #1;
        push("async_reset", exp_of(3'd0, 1'b0, 1'b0, 1'b0));
        it = sb.pop_front(); checks++;
        if (obs_w() !== it.val) begin
            errors++; $display("FAIL %s got=%h exp=%h", it.name, obs_w(), it.val);
        end
    endtask

    task automatic test_down_from_reset();
        sb_item_t it;
        do_reset();
        if_w.dir = 1'b0;
        if_w.en  = 1'b1;
        push("down_1", exp_of(3'd7, 1'b0, 1'b1, 1'b0));
        push("down_2", exp_of(3'd6, 1'b0, 1'b1, 1'b0));
        for (int k = 0; k < 2; k++) begin
            tick();
            it = sb.pop_front(); checks++;
            if (obs_w() !== it.val) begin
                errors++; $display("FAIL %s got=%h exp=%h", it.name, obs_w(), it.val);
            end
        end
    endtask

    task automatic test_saturate_up();
        sb_item_t it;
        do_reset();
        if_s.load       = 1'b1;
        if_s.load_value = 3'd6;
        push("sat_load6", exp_of(3'd6, 1'b0, 1'b0, 1'b0));
        tick();
        it = sb.pop_front(); checks++;
        if (obs_s() !== it.val) begin
            errors++; $display("FAIL %s got=%h exp=%h", it.name, obs_s(), it.val);
        end
        if_s.load = 1'b0;
        if_s.en   = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            push($sformatf("sat_up_%0d", k), exp_of(3'd7, k >= 2, 1'b0, 1'b1));
            tick();
            it = sb.pop_front(); checks++;
            if (obs_s() !== it.val) begin
                errors++; $display("FAIL %s got=%h exp=%h", it.name, obs_s(), it.val);
            end
        end
    endtask

    task automatic test_saturate_down();
        sb_item_t it;
        do_reset();
        if_s.dir = 1'b0;
        if_s.en  = 1'b1;
        push("sat_down_hold0", exp_of(3'd0, 1'b0, 1'b1, 1'b1));
        tick();
        it = sb.pop_front(); checks++;
        if (obs_s() !== it.val) begin
            errors++; $display("FAIL %s got=%h exp=%h", it.name, obs_s(), it.val);
        end
        if_s.en  = 1'b0;
        if_s.clr = 1'b1;
        push("sat_clr_udf", exp_of(3'd0, 1'b0, 1'b0, 1'b1));
        tick();
        it = sb.pop_front(); checks++;
        if (obs_s() !== it.val) begin
            errors++; $display("FAIL %s got=%h exp=%h", it.name, obs_s(), it.val);
        end
        if_s.clr = 1'b0;
    endtask

    // Load beats a simultaneous count; later clr drops overflow only.
    task automatic test_load_clr();
        sb_item_t it;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            unique case (k)
                0: begin
                    if_w.load = 1'b1; if_w.load_value = 3'd7; if_w.en = 1'b0;
                    push("lc_load7", exp_of(3'd7, 1'b0, 1'b0, 1'b1));
                end
                1: begin
                    if_w.load = 1'b0; if_w.en = 1'b1;
                    push("lc_wrap", exp_of(3'd0, 1'b1, 1'b0, 1'b0));
                end
                2: begin
                    if_w.load = 1'b1; if_w.load_value = 3'd5; if_w.en = 1'b1;
                    push("lc_load5_en", exp_of(3'd5, 1'b1, 1'b0, 1'b0));
                end
                default: begin
                    if_w.load = 1'b0; if_w.en = 1'b0; if_w.clr = 1'b1;
                    push("lc_clr", exp_of(3'd5, 1'b0, 1'b0, 1'b0));
                end
            endcase
            tick();
            it = sb.pop_front(); checks++;
            if (obs_w() !== it.val) begin
                errors++; $display("FAIL %s got=%h exp=%h", it.name, obs_w(), it.val);
            end
        end
        if_w.clr = 1'b0;
    endtask

    // Clear on the wrap edge loses to the set; next clear wins; term tracks dir.
    task automatic test_clr_vs_wrap();
        sb_item_t it;
        if_w.load = 1'b1; if_w.load_value = 3'd7; if_w.dir = 1'b1;
        push("cw_load7", exp_of(3'd7, 1'b0, 1'b0, 1'b1));
        tick();
        it = sb.pop_front(); checks++;
        if (obs_w() !== it.val) begin
            errors++; $display("FAIL %s got=%h exp=%h", it.name, obs_w(), it.val);
        end
        if_w.load = 1'b0; if_w.en = 1'b1; if_w.clr = 1'b1;
        push("cw_wrap_clr", exp_of(3'd0, 1'b1, 1'b0, 1'b0));
        tick();
        it = sb.pop_front(); checks++;
        if (obs_w() !== it.val) begin
            errors++; $display("FAIL %s got=%h exp=%h", it.name, obs_w(), it.val);
        end
        if_w.en = 1'b0;
        push("cw_clr", exp_of(3'd0, 1'b0, 1'b0, 1'b0));
        tick();
        it = sb.pop_front(); checks++;
        if (obs_w() !== it.val) begin
            errors++; $display("FAIL %s got=%h exp=%h", it.name, obs_w(), it.val);
        end
        if_w.clr = 1'b0;
        if_w.dir = 1'b0;
        #1;
        push("cw_term_dir", exp_of(3'd0, 1'b0, 1'b0, 1'b1));
        it = sb.pop_front(); checks++;
        if (obs_w() !== it.val) begin
            errors++; $display("FAIL %s got=%h exp=%h", it.name, obs_w(), it.val);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_up_wrap();
        test_hold_async_reset();
        test_down_from_reset();
        test_saturate_up();
        test_saturate_down();
        test_load_clr();
        test_clr_vs_wrap();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
